pe_mb: RTL
==========

Name: pe_mb

Overview:
Parametrised successor of the systolic-array processing element: a weight-stationary fixed-point MAC cell.
- Generalised data width and fraction bits; configurable saturation.
- Multi-bank weight storage, so several weight tiles can be preloaded and selected by index at switch time.
- Sticky overflow flag for debug and readback.
- Tiles into the same N/S/E/W mesh as the existing PE: the psum/weight/accept chain runs north→south; the input/valid/switch/select chain runs west→east.

Parameters:
- DATA_WIDTH, 16: width of input, weight and psum words (signed two's complement).
- FRAC_BITS, 8: fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); must be less than DATA_WIDTH.
- WBANKS, 2: number of shadow weight banks; power of two, at least 2.
- SATURATE, 1: 1 = clamp on overflow, 0 = wrap.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pe_enabled  in  1  low = synchronous clear of all state to reset values
- pe_psum_in  in  DATA_WIDTH  partial sum from north
- pe_weight_in  in  DATA_WIDTH  weight word from north
- pe_accept_w_in  in  1  write pe_weight_in into bank pe_wbank_in
- pe_wbank_in  in  $clog2(WBANKS)  write bank index
- pe_input_in  in  DATA_WIDTH  activation from west
- pe_valid_in  in  1  activation valid
- pe_switch_in  in  1  load active weight from bank pe_sel_in
- pe_sel_in  in  $clog2(WBANKS)  bank to activate on switch
- pe_psum_out  out  DATA_WIDTH  partial sum to south
- pe_weight_out  out  DATA_WIDTH  forwarded weight
- pe_accept_w_out  out  1  forwarded accept
- pe_wbank_out  out  $clog2(WBANKS)  forwarded write index
- pe_input_out  out  DATA_WIDTH  forwarded activation (also the MAC operand)
- pe_valid_out  out  1  forwarded valid
- pe_switch_out  out  1  forwarded switch
- pe_sel_out  out  $clog2(WBANKS)  forwarded select
- pe_overflow  out  1  sticky overflow flag

Behaviour:
- Reset (rst high, async) and pe_enabled low (sync, at posedge): every output, every bank and the active weight go to 0.
- Forwarding (posedge, enabled):
  - accept_w_out, switch_out, valid_out, wbank_out and sel_out take their inputs.
  - weight_out <= accept ? weight_in : 0.
  - input_out <= valid ? input_in : 0.
  - All forwarding paths have 1-cycle latency.
- Bank write: accept high → bank[wbank_in] <= weight_in at the edge.
- Switch: switch high → active_w <= bank[sel_in] at the edge.
  - The switch reads the pre-edge bank value; a same-cycle write to the same bank is not forwarded.
  - Writing a bank without a switch never changes active_w.
- MAC, computed combinationally from the registered operands:
  - p = input_out * active_w at full 2*DATA_WIDTH precision.
  - Shift p arithmetically right by FRAC_BITS (truncate toward −inf).
  - Add sign-extended pe_psum_in at DATA_WIDTH+1 bits.
  - Overflow when the shifted product or the sum falls outside the DATA_WIDTH signed range.
  - SATURATE=1: clamp to max/min. SATURATE=0: keep the low DATA_WIDTH bits.
  - psum_out <= result at every enabled edge, independent of valid. Zeroed inputs pass psum_in through unchanged.
- Latency:
  - Activation presented at edge t contributes to psum_out at edge t+1.
  - Switch at edge t affects psum_out from edge t+1 onward; activations presented at edge t already use the new weight.
- pe_overflow: set on any overflow at an enabled edge; cleared only by rst or pe_enabled low.
- Reset mid-load or mid-switch: all banks cleared; no partial state survives.

Decomposition:
- Package pe_pkg:
  - default DATA_WIDTH/FRAC_BITS constants
  - bank-index width helper
  - functions fxp_sat(value, width) and fxp_max/fxp_min
- Sub-module fxp_mac_sat: purely combinational multiply/shift/add/saturate, with out and overflow ports.
- pe_mb holds the registers, banks and forwarding logic.

Test Plan (defaults, Q8.8):
- Reset and clear: hold rst, then drop pe_enabled mid-run → all outputs, including pe_overflow, read 0; psum_out = 0 on the following edge.
- Basic MAC: write bank0=0x0200 (2.0), switch sel=0, input 0x0180 (1.5) valid, psum_in 0x0100 → psum_out 0x0400 one edge after the input edge; valid_out = 1.
- Multi-bank:
  - Preload bank0=0x0100, bank1=0xFF00 (−1.0). Switch sel=1, input 0x0300, psum_in 0 → psum_out 0xFD00.
  - Rewrite bank1 with no switch → result unchanged.
- Saturation:
  - bank=0x7F00, input 0x7F00, psum_in 0x7000 → psum_out 0x7FFF, pe_overflow=1 and stays 1 after later benign operands.
  - With SATURATE=0 → wrapped low bits.
- Simultaneous write/switch: accept with wbank=0 weight=0x0300 and switch sel=0 in the same cycle (old bank0=0x0100), input 0x0100 → product uses 1.0; a second switch then uses 3.0.
- Invalid input: valid low, input_in 0x1234, psum_in 0x0042 → input_out 0, psum_out 0x0042, weight_out 0 while accept is low.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants and fixed-point helpers for the PE mesh
package pe_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  // Width of a bank index; a single bank still gets a one-bit port.
  function automatic int bank_idx_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Largest signed value representable in `width` bits.
  function automatic logic signed [63:0] fxp_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in `width` bits.
  function automatic logic signed [63:0] fxp_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Clamp a wide signed value into the signed range of `width` bits.
  function automatic logic signed [63:0] fxp_sat(input logic signed [63:0] value,
                                                 input int width);
    logic signed [63:0] r;
    r = value;
    if (value > fxp_max(width)) r = fxp_max(width);
    else if (value < fxp_min(width)) r = fxp_min(width);
    return r;
  endfunction

endpackage

// File: rtl/fxp_mac_sat.sv
// rtl/fxp_mac_sat.sv - combinational fixed-point multiply, rescale, accumulate, saturate
module fxp_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int SATURATE   = 1
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] psum,
  output logic        [DATA_WIDTH-1:0] out,
  output logic                         overflow
);

  // Full-precision product width; must not exceed 64 for the package helpers.
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0]   P_MAX = PW'(fxp_max(DATA_WIDTH));
  localparam logic signed [PW-1:0]   P_MIN = PW'(fxp_min(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0]  O_MAX = DATA_WIDTH'(fxp_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0]  O_MIN = DATA_WIDTH'(fxp_min(DATA_WIDTH));

  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;
  logic [DATA_WIDTH-1:0]  p_dw;
  logic [DATA_WIDTH:0]    sum;
  logic                   prod_ovf;
  logic                   sum_ovf;

  // Product is rescaled by an arithmetic shift (floor), narrowed, then added one bit wide.
  always_comb begin
    prod     = PW'(a) * PW'(b);
    shifted  = prod >>> FRAC_BITS;
    prod_ovf = (shifted > P_MAX) || (shifted < P_MIN);
    if (SATURATE != 0) p_dw = DATA_WIDTH'(fxp_sat(64'(shifted), DATA_WIDTH));
    else               p_dw = shifted[DATA_WIDTH-1:0];
    sum      = {p_dw[DATA_WIDTH-1], p_dw} + {psum[DATA_WIDTH-1], psum};
    sum_ovf  = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
    out      = sum[DATA_WIDTH-1:0];
    if (SATURATE != 0 && sum_ovf) out = sum[DATA_WIDTH] ? O_MIN : O_MAX;
    overflow = prod_ovf | sum_ovf;
  end

endmodule

// File: rtl/pe_mb.sv
// rtl/pe_mb.sv - weight-stationary MAC processing element with banked weight storage
module pe_mb
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int WBANKS     = 2,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pe_enabled,
  input  logic [DATA_WIDTH-1:0]          pe_psum_in,
  input  logic [DATA_WIDTH-1:0]          pe_weight_in,
  input  logic                           pe_accept_w_in,
  input  logic [bank_idx_w(WBANKS)-1:0]  pe_wbank_in,
  input  logic [DATA_WIDTH-1:0]          pe_input_in,
  input  logic                           pe_valid_in,
  input  logic                           pe_switch_in,
  input  logic [bank_idx_w(WBANKS)-1:0]  pe_sel_in,
  output logic [DATA_WIDTH-1:0]          pe_psum_out,
  output logic [DATA_WIDTH-1:0]          pe_weight_out,
  output logic                           pe_accept_w_out,
  output logic [bank_idx_w(WBANKS)-1:0]  pe_wbank_out,
  output logic [DATA_WIDTH-1:0]          pe_input_out,
  output logic                           pe_valid_out,
  output logic                           pe_switch_out,
  output logic [bank_idx_w(WBANKS)-1:0]  pe_sel_out,
  output logic                           pe_overflow
);

  logic [DATA_WIDTH-1:0] bank [WBANKS];
  logic [DATA_WIDTH-1:0] active_w;
  logic [DATA_WIDTH-1:0] mac_out;
  logic                  mac_ovf;

  fxp_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .SATURATE   (SATURATE)
  ) u_mac (
    .a        (pe_input_out),
    .b        (active_w),
    .psum     (pe_psum_in),
    .out      (mac_out),
    .overflow (mac_ovf)
  );

  // Mesh forwarding registers; data words are zeroed when their qualifier is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_accept_w_out <= 1'b0;
      pe_weight_out   <= '0;
      pe_wbank_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_input_out    <= '0;
      pe_switch_out   <= 1'b0;
      pe_sel_out      <= '0;
    end else if (!pe_enabled) begin
      pe_accept_w_out <= 1'b0;
      pe_weight_out   <= '0;
      pe_wbank_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_input_out    <= '0;
      pe_switch_out   <= 1'b0;
      pe_sel_out      <= '0;
    end else begin
      pe_accept_w_out <= pe_accept_w_in;
      pe_weight_out   <= pe_accept_w_in ? pe_weight_in : '0;
      pe_wbank_out    <= pe_wbank_in;
      pe_valid_out    <= pe_valid_in;
      pe_input_out    <= pe_valid_in ? pe_input_in : '0;
      pe_switch_out   <= pe_switch_in;
      pe_sel_out      <= pe_sel_in;
    end
  end

  // Shadow banks and the active weight; a switch samples the bank before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WBANKS; i++) bank[i] <= '0;
      active_w <= '0;
    end else if (!pe_enabled) begin
      for (int i = 0; i < WBANKS; i++) bank[i] <= '0;
      active_w <= '0;
    end else begin
      if (pe_accept_w_in) bank[pe_wbank_in] <= pe_weight_in;
      if (pe_switch_in)   active_w <= bank[pe_sel_in];
    end
  end

  // Registered MAC result every enabled edge, plus the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_psum_out <= '0;
      pe_overflow <= 1'b0;
    end else if (!pe_enabled) begin
      pe_psum_out <= '0;
      pe_overflow <= 1'b0;
    end else begin
      pe_psum_out <= mac_out;
      if (mac_ovf) pe_overflow <= 1'b1;
    end
  end

endmodule
